// File: rtl/sfp_peer_sum_rd_if.sv
// Bus bundle between the core controller / peer FIFO side and sfp_peer_sum_rd.
// The single_core signal exists only when SFP_PEER_BYPASS_EN is defined.
interface sfp_peer_sum_rd_if #(
  parameter int SUM_BW = 24
);
  logic              peer_empty;
  logic              peer_rd;
  logic [SUM_BW-1:0] peer_sum;
  logic              div_req;
  logic              div;
  logic [SUM_BW-1:0] sum_in;
  logic [3:0]        pend_cnt;
  logic [7:0]        rows_done;
  logic              req_ovf;
`ifdef SFP_PEER_BYPASS_EN
  logic              single_core;

  modport master (
    output peer_empty, peer_sum, div_req, single_core,
    input  peer_rd, div, sum_in, pend_cnt, rows_done, req_ovf
  );

  modport slave (
    input  peer_empty, peer_sum, div_req, single_core,
    output peer_rd, div, sum_in, pend_cnt, rows_done, req_ovf
  );
`else
  modport master (
    output peer_empty, peer_sum, div_req,
    input  peer_rd, div, sum_in, pend_cnt, rows_done, req_ovf
  );

  modport slave (
    input  peer_empty, peer_sum, div_req,
    output peer_rd, div, sum_in, pend_cnt, rows_done, req_ovf
  );
`endif
endinterface

// File: rtl/sfp_peer_sum_rd.sv
// Read side of the cross-core partial-sum link: prefetches peer sums, issues sfp_row divides.
// Define SFP_PEER_BYPASS_EN to add the single_core bypass (zero sum, no peer reads).
module sfp_peer_sum_rd #(
  parameter int BW      = 8,
  parameter int BW_PSUM = 2*BW+4,
  parameter int SUM_BW  = BW_PSUM+4,
  parameter int DEPTH   = 4
) (
  input logic              clk,
  input logic              reset_n,
  sfp_peer_sum_rd_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW:0] DEPTH_V = DEPTH[OW:0];

  logic [SUM_BW-1:0] buf_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [OW-1:0]     occ_q;
  logic [OW-1:0]     occ_d;
  logic              inflight_q;
  logic              div_q;
  logic              div_d;
  logic [SUM_BW-1:0] sum_in_q;
  logic [SUM_BW-1:0] sum_in_d;
  logic [3:0]        pend_q;
  logic [3:0]        pend_d;
  logic [7:0]        rows_q;
  logic [7:0]        rows_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              bypass;
  logic              peer_rd;
  logic              issue;
  logic              pop;
  logic [OW:0]       used;

`ifdef SFP_PEER_BYPASS_EN
  assign bypass = bus.single_core;
`else
  assign bypass = 1'b0;
`endif

  // An in-flight read already owns a slot, so it counts toward the fill level.
  assign used    = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
  assign peer_rd = reset_n && !bypass && !bus.peer_empty && (used < DEPTH_V);

  assign issue = (pend_q != 4'd0) && !div_q && (bypass || (occ_q != '0));
  assign pop   = issue && !bypass;

  always_comb begin
    occ_d    = occ_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    div_d    = issue;
    sum_in_d = sum_in_q;
    rows_d   = rows_q;

    case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // A request landing on an issue cycle cancels out and can never overflow.
    if (bus.div_req && !issue) begin
      if (pend_q == 4'hF) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (!bus.div_req && issue) begin
      pend_d = pend_q - 4'd1;
    end

    if (issue) begin
      sum_in_d = bypass ? '0 : buf_q[rd_ptr_q];
      rows_d   = rows_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      div_q      <= 1'b0;
      sum_in_q   <= '0;
      pend_q     <= '0;
      rows_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      inflight_q <= peer_rd;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= bus.peer_sum;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      occ_q    <= occ_d;
      div_q    <= div_d;
      sum_in_q <= sum_in_d;
      pend_q   <= pend_d;
      rows_q   <= rows_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.peer_rd   = peer_rd;
  assign bus.div       = div_q;
  assign bus.sum_in    = sum_in_q;
  assign bus.pend_cnt  = pend_q;
  assign bus.rows_done = rows_q;
  assign bus.req_ovf   = ovf_q;

endmodule

// File: tb/tb_sfp_peer_sum_rd.sv
// Directed bench for sfp_peer_sum_rd with a behavioural peer FIFO (data one cycle after read).
module tb_sfp_peer_sum_rd;
  localparam int SUM_BW = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [SUM_BW-1:0] pdata [64];
  int   wr_cnt = 0;
  int   rd_idx = 0;
  logic hold = 1'b0;
  logic flush_req = 1'b0;

  logic [SUM_BW-1:0] dlog [256];
  int   div_cnt = 0;
  int   consec = 0;
  logic prev_div = 1'b0;

  sfp_peer_sum_rd_if #(.SUM_BW(SUM_BW)) bus ();

  sfp_peer_sum_rd #(
    .BW(8), .BW_PSUM(20), .SUM_BW(SUM_BW), .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Peer FIFO model
  assign bus.peer_empty = hold || (rd_idx >= wr_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush_req) begin
      rd_idx <= wr_cnt;
    end else if (bus.peer_rd === 1'b1) begin
      bus.peer_sum <= pdata[rd_idx];
      rd_idx       <= rd_idx + 1;
    end
  end

  // Divide monitor
  always @(negedge clk) begin
    if (bus.div === 1'b1) begin
      dlog[div_cnt] = bus.sum_in;
      div_cnt++;
      if (prev_div) consec++;
    end
    prev_div = (bus.div === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [SUM_BW-1:0] v);
    pdata[wr_cnt] = v;
    wr_cnt++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hold = 1'b1;
    flush_req = 1'b1;
    bus.div_req = 1'b0;
    step();
    step();
    flush_req = 1'b0;
    reset_n = 1'b1;
    hold = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int k;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 6; i++) push(24'h100000 + 24'(i));
    step();
    step();
    checks++;
    if (bus.peer_rd !== 1'b0) begin
      errors++; $display("FAIL rst_peer_rd_low: got %b expected 0", bus.peer_rd);
    end
    checks++;
    if ({bus.div, bus.req_ovf, bus.pend_cnt, bus.rows_done, bus.sum_in} !== 38'd0) begin
      errors++; $display("FAIL rst_outputs: div=%b ovf=%b pend=%h rows=%h sum=%h expected all 0",
                         bus.div, bus.req_ovf, bus.pend_cnt, bus.rows_done, bus.sum_in);
    end
    reset_n = 1'b1;
    bus.div_req = 1'b1;
    step();
    bus.div_req = 1'b0;
    k = 0;
    while (bus.rows_done !== 8'd1 && k < 10) begin
      step();
      k++;
    end
    checks++;
    if (bus.rows_done !== 8'd1) begin
      errors++; $display("FAIL pre_rst_rows: got %0d expected 1", bus.rows_done);
    end
    checks++;
    if (bus.sum_in !== 24'h100000) begin
      errors++; $display("FAIL pre_rst_sum: got %h expected 100000", bus.sum_in);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.peer_rd !== 1'b0 || bus.peer_empty !== 1'b0) begin
      errors++; $display("FAIL async_rst_peer_rd: got %b (empty=%b) expected 0 with peer non-empty",
                         bus.peer_rd, bus.peer_empty);
    end
    checks++;
    if ({bus.div, bus.req_ovf, bus.pend_cnt, bus.rows_done, bus.sum_in} !== 38'd0) begin
      errors++; $display("FAIL async_rst_outputs: div=%b ovf=%b pend=%h rows=%h sum=%h expected all 0",
                         bus.div, bus.req_ovf, bus.pend_cnt, bus.rows_done, bus.sum_in);
    end
  endtask

  task automatic test_basic();
    int base;
    int c0;
    int d0;
    int cs;
    do_reset();
    base = div_cnt;
    cs = consec;
    c0 = cyc;
    push(24'h000120);
    push(24'h0000FF);
    bus.div_req = 1'b1;
    #1;
    checks++;
    if (bus.peer_rd !== 1'b1) begin
      errors++; $display("FAIL basic_first_peer_rd: got %b expected 1", bus.peer_rd);
    end
    step();
    step();
    bus.div_req = 1'b0;
    d0 = -1;
    for (int k = 0; k < 12; k++) begin
      if (bus.div === 1'b1 && d0 < 0) d0 = cyc;
      step();
    end
    // peer_rd sampled at edge c0+1, div set two edges later (c0+3).
    checks++;
    if (d0 - c0 != 3) begin
      errors++; $display("FAIL basic_latency: got %0d cycles expected 3", d0 - c0);
    end
    checks++;
    if (div_cnt - base != 2) begin
      errors++; $display("FAIL basic_div_count: got %0d expected 2", div_cnt - base);
    end
    checks++;
    if (dlog[base] !== 24'h000120) begin
      errors++; $display("FAIL basic_sum0: got %h expected 000120", dlog[base]);
    end
    checks++;
    if (dlog[base+1] !== 24'h0000FF) begin
      errors++; $display("FAIL basic_sum1: got %h expected 0000ff", dlog[base+1]);
    end
    checks++;
    if (bus.rows_done !== 8'd2 || bus.pend_cnt !== 4'd0) begin
      errors++; $display("FAIL basic_counters: rows=%0d pend=%0d expected 2 and 0",
                         bus.rows_done, bus.pend_cnt);
    end
    checks++;
    if (consec != cs || bus.sum_in !== 24'h0000FF) begin
      errors++; $display("FAIL basic_hold: consec=%0d sum=%h expected 0 and 0000ff",
                         consec - cs, bus.sum_in);
    end
  endtask

  task automatic test_prefetch();
    logic [SUM_BW-1:0] w [6];
    int base;
    int r0;
    int cs;
    w = '{24'hA50001, 24'h00BEEF, 24'hFFFFFF, 24'h800000, 24'h123456, 24'h0F0F0F};
    do_reset();
    base = div_cnt;
    r0 = rd_idx;
    cs = consec;
    for (int i = 0; i < 6; i++) push(w[i]);
    repeat (12) step();
    checks++;
    if (rd_idx - r0 != 4) begin
      errors++; $display("FAIL prefetch_reads: got %0d expected 4", rd_idx - r0);
    end
    checks++;
    if (bus.peer_rd !== 1'b0) begin
      errors++; $display("FAIL prefetch_full_rd: got %b expected 0", bus.peer_rd);
    end
    for (int i = 0; i < 5; i++) begin
      bus.div_req = 1'b1;
      step();
    end
    bus.div_req = 1'b0;
    repeat (25) step();
    checks++;
    if (div_cnt - base != 5) begin
      errors++; $display("FAIL prefetch_div_count: got %0d expected 5", div_cnt - base);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dlog[base+i] !== w[i]) begin
        errors++; $display("FAIL prefetch_order[%0d]: got %h expected %h", i, dlog[base+i], w[i]);
      end
    end
    checks++;
    if (consec != cs) begin
      errors++; $display("FAIL prefetch_consecutive: got %0d expected 0", consec - cs);
    end
    checks++;
    if (bus.rows_done !== 8'd5 || bus.pend_cnt !== 4'd0 || rd_idx - r0 != 6) begin
      errors++; $display("FAIL prefetch_final: rows=%0d pend=%0d reads=%0d expected 5 0 6",
                         bus.rows_done, bus.pend_cnt, rd_idx - r0);
    end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    base = div_cnt;
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(24'h300000 + 24'(i));
    for (int i = 0; i < 16; i++) begin
      bus.div_req = 1'b1;
      step();
    end
    bus.div_req = 1'b0;
    step();
    checks++;
    if (bus.pend_cnt !== 4'd15) begin
      errors++; $display("FAIL ovf_pend_sat: got %0d expected 15", bus.pend_cnt);
    end
    checks++;
    if (bus.req_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got %b expected 1", bus.req_ovf);
    end
    checks++;
    if (bus.div !== 1'b0 || div_cnt != base) begin
      errors++; $display("FAIL ovf_no_div: div=%b count=%0d expected 0 0", bus.div, div_cnt - base);
    end
    hold = 1'b0;
    repeat (60) step();
    checks++;
    if (div_cnt - base != 15) begin
      errors++; $display("FAIL ovf_div_count: got %0d expected 15", div_cnt - base);
    end
    checks++;
    if (bus.pend_cnt !== 4'd0 || bus.rows_done !== 8'd15) begin
      errors++; $display("FAIL ovf_drain: pend=%0d rows=%0d expected 0 15", bus.pend_cnt, bus.rows_done);
    end
    checks++;
    if (dlog[base] !== 24'h300000 || bus.sum_in !== 24'h30000E) begin
      errors++; $display("FAIL ovf_data: first=%h last=%h expected 300000 30000e", dlog[base], bus.sum_in);
    end
    checks++;
    if (bus.req_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.req_ovf);
    end
  endtask

  task automatic test_reset_mid_read();
    int base;
    int k;
    do_reset();
    base = div_cnt;
    push(24'h00AAAA);
    #1;
    checks++;
    if (bus.peer_rd !== 1'b1) begin
      errors++; $display("FAIL midrst_peer_rd: got %b expected 1", bus.peer_rd);
    end
    step();
    reset_n = 1'b0;
    hold = 1'b1;
    push(24'h00BBBB);
    step();
    reset_n = 1'b1;
    step();
    bus.div_req = 1'b1;
    step();
    bus.div_req = 1'b0;
    repeat (5) step();
    checks++;
    if (div_cnt != base || bus.pend_cnt !== 4'd1) begin
      errors++; $display("FAIL midrst_discard: divs=%0d pend=%0d expected 0 1", div_cnt - base, bus.pend_cnt);
    end
    hold = 1'b0;
    k = 0;
    while (div_cnt - base < 1 && k < 10) begin
      step();
      k++;
    end
    checks++;
    if (div_cnt - base != 1) begin
      errors++; $display("FAIL midrst_div_timeout: got %0d divs expected 1", div_cnt - base);
    end
    checks++;
    if (bus.sum_in !== 24'h00BBBB || bus.rows_done !== 8'd1) begin
      errors++; $display("FAIL midrst_next_word: sum=%h rows=%0d expected 00bbbb 1", bus.sum_in, bus.rows_done);
    end
  endtask

`ifdef SFP_PEER_BYPASS_EN
  task automatic test_bypass();
    int base;
    int r0;
    do_reset();
    bus.single_core = 1'b1;
    base = div_cnt;
    r0 = rd_idx;
    for (int i = 0; i < 3; i++) push(24'h777000 + 24'(i));
    for (int i = 0; i < 3; i++) begin
      bus.div_req = 1'b1;
      step();
    end
    bus.div_req = 1'b0;
    repeat (10) step();
    checks++;
    if (div_cnt - base != 3) begin
      errors++; $display("FAIL bypass_div_count: got %0d expected 3", div_cnt - base);
    end
    checks++;
    if (dlog[base] !== '0 || dlog[base+2] !== '0 || bus.sum_in !== '0) begin
      errors++; $display("FAIL bypass_sum_zero: got %h/%h/%h expected 0", dlog[base], dlog[base+2], bus.sum_in);
    end
    checks++;
    if (rd_idx != r0 || bus.pend_cnt !== 4'd0) begin
      errors++; $display("FAIL bypass_no_read: reads=%0d pend=%0d expected 0 0", rd_idx - r0, bus.pend_cnt);
    end
    bus.single_core = 1'b0;
  endtask
`endif

  initial begin
    bus.div_req = 1'b0;
`ifdef SFP_PEER_BYPASS_EN
    bus.single_core = 1'b0;
`endif
    test_reset();
    test_basic();
    test_prefetch();
    test_overflow();
    test_reset_mid_read();
`ifdef SFP_PEER_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
